// File: rtl/iob_seg_scan.sv
// Multiplexed common-anode 7-segment scan controller with double-buffered digit data.
// Registered outputs; new data takes effect only at a frame boundary or while idle.
module iob_seg_scan #(
   parameter int DIG_N    = 4,
   parameter int PRESCALE = 50000,
   parameter int BLANK    = 16,
   parameter int CNT_W    = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               en,
   input  logic [4*DIG_N-1:0] digits_i,
   input  logic [DIG_N-1:0]   dp_i,
   input  logic [DIG_N-1:0]   dig_en_i,
   input  logic               load_i,
   output logic               load_ack_o,
   output logic               frame_o,
   output logic [6:0]         seg_cat,
   output logic               seg_dp,
   output logic [DIG_N-1:0]   seg_anode
);

   localparam int IDX_W = (DIG_N > 1) ? $clog2(DIG_N) : 1;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_BLANK = 2'd1;
   localparam logic [1:0] S_SHOW  = 2'd2;

   // Slot entry state: skip the blanking phase entirely when BLANK is zero.
   localparam logic [1:0] S_ENTRY = (BLANK == 0) ? S_SHOW : S_BLANK;

   function automatic logic [6:0] decode(input logic [3:0] d);
      case (d)
         4'h0: decode = 7'h3F;  4'h1: decode = 7'h06;
         4'h2: decode = 7'h5B;  4'h3: decode = 7'h4F;
         4'h4: decode = 7'h66;  4'h5: decode = 7'h6D;
         4'h6: decode = 7'h7D;  4'h7: decode = 7'h07;
         4'h8: decode = 7'h7F;  4'h9: decode = 7'h6F;
         4'hA: decode = 7'h77;  4'hB: decode = 7'h7C;
         4'hC: decode = 7'h39;  4'hD: decode = 7'h5E;
         4'hE: decode = 7'h79;  default: decode = 7'h71;
      endcase
   endfunction

   logic [1:0]         st, st_n;
   logic [IDX_W-1:0]   idx, idx_n;
   logic [CNT_W-1:0]   cnt, cnt_n;
   logic [4*DIG_N-1:0] act_dig, act_dig_n, pnd_dig, pnd_dig_n;
   logic [DIG_N-1:0]   act_dp, act_dp_n, pnd_dp, pnd_dp_n;
   logic [DIG_N-1:0]   act_en, act_en_n, pnd_en, pnd_en_n;
   logic               pend, pend_n;
   logic               slot_end, last_dig, boundary;
   logic               ack_n, frame_n, dp_n;
   logic [6:0]         cat_n;
   logic [DIG_N-1:0]   anode_n;

   assign slot_end = (st != S_IDLE) && (cnt == CNT_W'(PRESCALE - 1));
   assign last_dig = (idx == IDX_W'(DIG_N - 1));
   assign boundary = (st == S_IDLE) || (en && slot_end && last_dig);

   always_comb begin
      st_n  = st;
      idx_n = idx;
      cnt_n = cnt;
      if (!en) begin
         st_n  = S_IDLE;
         idx_n = '0;
         cnt_n = '0;
      end else if (st == S_IDLE) begin
         st_n  = S_ENTRY;
         idx_n = '0;
         cnt_n = '0;
      end else if (slot_end) begin
         st_n  = S_ENTRY;
         cnt_n = '0;
         idx_n = last_dig ? '0 : idx + 1'b1;
      end else begin
         cnt_n = cnt + 1'b1;
         if (st == S_BLANK && cnt == CNT_W'(BLANK - 1))
            st_n = S_SHOW;
      end
   end

   // A load coinciding with a boundary bypasses the pending buffer.
   always_comb begin
      act_dig_n = act_dig;
      act_dp_n  = act_dp;
      act_en_n  = act_en;
      pnd_dig_n = pnd_dig;
      pnd_dp_n  = pnd_dp;
      pnd_en_n  = pnd_en;
      pend_n    = pend;
      ack_n     = 1'b0;
      if (boundary) begin
         if (load_i) begin
            act_dig_n = digits_i;
            act_dp_n  = dp_i;
            act_en_n  = dig_en_i;
         end else if (pend) begin
            act_dig_n = pnd_dig;
            act_dp_n  = pnd_dp;
            act_en_n  = pnd_en;
         end
         ack_n  = load_i | pend;
         pend_n = 1'b0;
      end else if (load_i) begin
         pnd_dig_n = digits_i;
         pnd_dp_n  = dp_i;
         pnd_en_n  = dig_en_i;
         pend_n    = 1'b1;
      end
   end

   always_comb begin
      anode_n = '1;
      cat_n   = 7'h7F;
      dp_n    = 1'b1;
      frame_n = en && slot_end && last_dig;
      if (st_n == S_SHOW) begin
         cat_n = ~decode(act_dig_n[idx_n*4 +: 4]);
         dp_n  = ~act_dp_n[idx_n];
         if (act_en_n[idx_n])
            anode_n = ~(DIG_N'(1) << idx_n);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         st         <= S_IDLE;
         idx        <= '0;
         cnt        <= '0;
         act_dig    <= '0;
         act_dp     <= '0;
         act_en     <= '0;
         pnd_dig    <= '0;
         pnd_dp     <= '0;
         pnd_en     <= '0;
         pend       <= 1'b0;
         load_ack_o <= 1'b0;
         frame_o    <= 1'b0;
         seg_cat    <= 7'h7F;
         seg_dp     <= 1'b1;
         seg_anode  <= '1;
      end else begin
         st         <= st_n;
         idx        <= idx_n;
         cnt        <= cnt_n;
         act_dig    <= act_dig_n;
         act_dp     <= act_dp_n;
         act_en     <= act_en_n;
         pnd_dig    <= pnd_dig_n;
         pnd_dp     <= pnd_dp_n;
         pnd_en     <= pnd_en_n;
         pend       <= pend_n;
         load_ack_o <= ack_n;
         frame_o    <= frame_n;
         seg_cat    <= cat_n;
         seg_dp     <= dp_n;
         seg_anode  <= anode_n;
      end
   end

endmodule

// File: tb/tb_iob_seg_scan.sv
// Bench for iob_seg_scan (4 digits, 8-cycle slots, 2 blank cycles) against a
// position-based reference model: slot and phase are derived from cycles since scan start.
module tb_iob_seg_scan;
   localparam int D = 4;
   localparam int P = 8;
   localparam int B = 2;
   localparam int FRAME = D * P;

   logic        clk = 1'b0;
   logic        rst, en, load_i;
   logic [15:0] digits_i;
   logic [3:0]  dp_i, dig_en_i;
   logic        load_ack_o, frame_o, seg_dp;
   logic [6:0]  seg_cat;
   logic [3:0]  seg_anode;

   iob_seg_scan #(.DIG_N(D), .PRESCALE(P), .BLANK(B), .CNT_W(16)) dut (
      .clk(clk), .rst(rst), .en(en), .digits_i(digits_i), .dp_i(dp_i),
      .dig_en_i(dig_en_i), .load_i(load_i), .load_ack_o(load_ack_o),
      .frame_o(frame_o), .seg_cat(seg_cat), .seg_dp(seg_dp), .seg_anode(seg_anode)
   );

   always #5 clk = ~clk;

   logic [6:0] seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   // reference model state
   bit          m_scan, m_pend;
   int          m_n;
   logic [15:0] m_act_dig, m_pnd_dig;
   logic [3:0]  m_act_dp, m_act_en, m_pnd_dp, m_pnd_en;
   logic [3:0]  exp_anode;
   logic [6:0]  exp_cat;
   logic        exp_dp, exp_ack, exp_frame;

   task automatic model_reset();
      m_scan = 0; m_pend = 0; m_n = 0;
      m_act_dig = '0; m_act_dp = '0; m_act_en = '0;
      m_pnd_dig = '0; m_pnd_dp = '0; m_pnd_en = '0;
      exp_anode = 4'hF; exp_cat = 7'h7F; exp_dp = 1'b1; exp_ack = 1'b0; exp_frame = 1'b0;
   endtask

   // Advance the model by one clock using the current inputs, then clock the DUT.
   task automatic step();
      bit bnd;
      int w, s;
      bnd = !m_scan || (en && (m_n % FRAME) == FRAME - 1);
      exp_frame = m_scan && en && (m_n % FRAME) == FRAME - 1;
      exp_ack = bnd && (load_i || m_pend);
      if (bnd) begin
         if (load_i) begin
            m_act_dig = digits_i; m_act_dp = dp_i; m_act_en = dig_en_i;
         end else if (m_pend) begin
            m_act_dig = m_pnd_dig; m_act_dp = m_pnd_dp; m_act_en = m_pnd_en;
         end
         m_pend = 0;
      end else if (load_i) begin
         m_pnd_dig = digits_i; m_pnd_dp = dp_i; m_pnd_en = dig_en_i; m_pend = 1;
      end
      if (!en) begin
         m_scan = 0; m_n = 0;
      end else if (!m_scan) begin
         m_scan = 1; m_n = 0;
      end else begin
         m_n++;
      end
      exp_anode = 4'hF; exp_cat = 7'h7F; exp_dp = 1'b1;
      if (m_scan) begin
         w = m_n % P;
         s = (m_n / P) % D;
         if (w >= B) begin
            exp_cat = ~seg_tab[m_act_dig[4*s +: 4]];
            exp_dp  = ~m_act_dp[s];
            if (m_act_en[s]) exp_anode = ~(4'b0001 << s);
         end
      end
      @(posedge clk); #1;
      cyc++;
   endtask

   task automatic test_reset();
      rst = 1; en = 0; load_i = 0; digits_i = '0; dp_i = '0; dig_en_i = '0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if ({seg_anode, seg_cat, seg_dp, load_ack_o, frame_o} !== {4'hF, 7'h7F, 1'b1, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL reset_outputs: got an=%h cat=%h dp=%b ack=%b fr=%b, want an=f cat=7f dp=1 ack=0 fr=0",
                  seg_anode, seg_cat, seg_dp, load_ack_o, frame_o);
      end
      rst = 0;
      step();
      checks++;
      if ({seg_anode, load_ack_o, frame_o} !== {4'hF, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL reset_idle: got an=%h ack=%b fr=%b, want an=f ack=0 fr=0", seg_anode, load_ack_o, frame_o);
      end
   endtask

   task automatic test_idle_load();
      int bad = 0;
      digits_i = 16'h1234; dp_i = 4'b0000; dig_en_i = 4'hF; load_i = 1;
      step();
      load_i = 0;
      checks++;
      if (load_ack_o !== 1'b1) begin
         errors++;
         $display("FAIL idle_load_ack: got %b, want 1", load_ack_o);
      end
      en = 1;
      for (int i = 0; i < 40; i++) begin
         step();
         if (i == 2) begin
            checks++;
            if ({seg_anode, seg_cat} !== {4'b1110, ~7'h66}) begin
               errors++;
               $display("FAIL idle_load_digit0: got an=%b cat=%h, want an=1110 cat=%h", seg_anode, seg_cat, ~7'h66);
            end
         end
         if (i == 10) begin
            checks++;
            if ({seg_anode, seg_cat} !== {4'b1101, ~7'h4F}) begin
               errors++;
               $display("FAIL idle_load_digit1: got an=%b cat=%h, want an=1101 cat=%h", seg_anode, seg_cat, ~7'h4F);
            end
         end
         if ({seg_anode, seg_cat, seg_dp, load_ack_o, frame_o} !== {exp_anode, exp_cat, exp_dp, exp_ack, exp_frame})
            bad++;
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL idle_load_scan: %0d mismatching cycles, want 0", bad);
      end
   endtask

   task automatic test_midframe_load();
      int bad = 0, acks = 0, ack_at = -1;
      for (int i = 0; i < 64 && (m_n % FRAME) != 5; i++) step();
      digits_i = 16'hABCD; load_i = 1;
      step();
      load_i = 0;
      for (int i = 0; i < 70; i++) begin
         step();
         if (load_ack_o) begin acks++; ack_at = m_n; end
         if (ack_at >= 0 && m_n == ack_at + 2 && (m_n % FRAME) == 2) begin
            checks++;
            if ({seg_anode, seg_cat} !== {4'b1110, ~7'h5E}) begin
               errors++;
               $display("FAIL midframe_new_digit: got an=%b cat=%h, want an=1110 cat=%h", seg_anode, seg_cat, ~7'h5E);
            end
         end
         if ({seg_anode, seg_cat, seg_dp, load_ack_o, frame_o} !== {exp_anode, exp_cat, exp_dp, exp_ack, exp_frame})
            bad++;
      end
      checks++;
      if (acks != 1 || (ack_at % FRAME) != 0) begin
         errors++;
         $display("FAIL midframe_ack: got %0d acks at frame pos %0d, want 1 at pos 0", acks, ack_at % FRAME);
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL midframe_scan: %0d mismatching cycles, want 0", bad);
      end
   endtask

   task automatic test_dig_en();
      int bad = 0, lit13 = 0, last_fr = -1, bad_period = 0, frames = 0;
      bit applied = 0;
      dig_en_i = 4'b0101; digits_i = 16'h8888; dp_i = 4'hF; load_i = 1;
      step();
      load_i = 0;
      for (int i = 0; i < 140; i++) begin
         step();
         if (load_ack_o) applied = 1;
         if (applied && (seg_anode[1] === 1'b0 || seg_anode[3] === 1'b0)) lit13++;
         if (frame_o) begin
            if (last_fr >= 0 && cyc - last_fr != FRAME) bad_period++;
            last_fr = cyc;
            frames++;
         end
         if ({seg_anode, seg_cat, seg_dp, load_ack_o, frame_o} !== {exp_anode, exp_cat, exp_dp, exp_ack, exp_frame})
            bad++;
      end
      checks++;
      if (!applied || lit13 != 0) begin
         errors++;
         $display("FAIL dig_en_masked: applied=%b, anode 1/3 low %0d times, want applied=1 and 0", applied, lit13);
      end
      checks++;
      if (bad_period != 0 || frames < 3) begin
         errors++;
         $display("FAIL dig_en_frame_period: %0d bad periods over %0d frames, want 0 over >=3", bad_period, frames);
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL dig_en_scan: %0d mismatching cycles, want 0", bad);
      end
   endtask

   task automatic test_en_drop();
      for (int i = 0; i < 64 && (m_n % P) != 4; i++) step();
      en = 0;
      step();
      checks++;
      if ({seg_anode, seg_cat, seg_dp, frame_o} !== {4'hF, 7'h7F, 1'b1, 1'b0}) begin
         errors++;
         $display("FAIL en_drop_dark: got an=%h cat=%h dp=%b fr=%b, want an=f cat=7f dp=1 fr=0",
                  seg_anode, seg_cat, seg_dp, frame_o);
      end
      step();
      en = 1;
      step();
      checks++;
      if ({seg_anode, seg_cat} !== {4'hF, 7'h7F}) begin
         errors++;
         $display("FAIL en_restart_blank: got an=%h cat=%h, want an=f cat=7f", seg_anode, seg_cat);
      end
      step(); step();
      checks++;
      if ({seg_anode, seg_cat, seg_dp} !== {4'b1110, ~7'h7F, 1'b0}) begin
         errors++;
         $display("FAIL en_restart_digit0: got an=%b cat=%h dp=%b, want an=1110 cat=%h dp=0",
                  seg_anode, seg_cat, seg_dp, ~7'h7F);
      end
   endtask

   task automatic test_double_load_rst();
      int acks = 0, bad = 0;
      for (int i = 0; i < 64 && (m_n % FRAME) != 4; i++) step();
      digits_i = 16'h1111; dig_en_i = 4'hF; dp_i = 4'h0; load_i = 1; step(); load_i = 0;
      step(); step();
      digits_i = 16'h2222; load_i = 1; step(); load_i = 0;
      step(); step(); step();
      rst = 1;
      #1;
      checks++;
      if ({seg_anode, seg_cat, seg_dp, load_ack_o, frame_o} !== {4'hF, 7'h7F, 1'b1, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL rst_async_dark: got an=%h cat=%h dp=%b ack=%b fr=%b, want an=f cat=7f dp=1 ack=0 fr=0",
                  seg_anode, seg_cat, seg_dp, load_ack_o, frame_o);
      end
      @(posedge clk); #1;
      rst = 0;
      model_reset();
      for (int i = 0; i < 40; i++) begin
         step();
         if (load_ack_o) acks++;
         if ({seg_anode, seg_cat, seg_dp, load_ack_o, frame_o} !== {exp_anode, exp_cat, exp_dp, exp_ack, exp_frame})
            bad++;
      end
      checks++;
      if (acks != 0) begin
         errors++;
         $display("FAIL rst_discard_pending: got %0d acks, want 0", acks);
      end
      for (int i = 0; i < 64 && (m_n % FRAME) != 6; i++) step();
      digits_i = 16'h3333; load_i = 1; step(); load_i = 0;
      step(); step();
      digits_i = 16'h4444; load_i = 1; step(); load_i = 0;
      for (int i = 0; i < 40; i++) begin
         step();
         if (load_ack_o) acks++;
         if ((m_n % FRAME) == 3 && acks == 1) begin
            checks++;
            if (seg_cat !== ~7'h66) begin
               errors++;
               $display("FAIL double_load_second_data: got cat=%h, want %h", seg_cat, ~7'h66);
            end
         end
         if ({seg_anode, seg_cat, seg_dp, load_ack_o, frame_o} !== {exp_anode, exp_cat, exp_dp, exp_ack, exp_frame})
            bad++;
      end
      checks++;
      if (acks != 1) begin
         errors++;
         $display("FAIL double_load_single_ack: got %0d acks, want 1", acks);
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL double_load_scan: %0d mismatching cycles, want 0", bad);
      end
   endtask

   task automatic test_random();
      int bad = 0, model_acks = 0, dut_acks = 0;
      for (int i = 0; i < 600; i++) begin
         en = ($urandom_range(0, 39) != 0);
         load_i = ($urandom_range(0, 11) == 0);
         digits_i = 16'($urandom);
         dp_i = 4'($urandom);
         dig_en_i = 4'($urandom);
         step();
         if (exp_ack) model_acks++;
         if (load_ack_o) dut_acks++;
         if ({seg_anode, seg_cat, seg_dp, load_ack_o, frame_o} !== {exp_anode, exp_cat, exp_dp, exp_ack, exp_frame}) begin
            bad++;
            if (bad <= 3)
               $display("FAIL random_cycle%0d: got an=%h cat=%h dp=%b ack=%b fr=%b, want an=%h cat=%h dp=%b ack=%b fr=%b",
                        i, seg_anode, seg_cat, seg_dp, load_ack_o, frame_o,
                        exp_anode, exp_cat, exp_dp, exp_ack, exp_frame);
         end
      end
      load_i = 0; en = 1;
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL random_scan: %0d mismatching cycles, want 0", bad);
      end
      checks++;
      if (dut_acks != model_acks) begin
         errors++;
         $display("FAIL random_ack_count: got %0d, want %0d", dut_acks, model_acks);
      end
   endtask

   initial begin
      test_reset();
      test_idle_load();
      test_midframe_load();
      test_dig_en();
      test_en_drop();
      test_double_load_rst();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
